// File: rtl/cic_interp.sv
// Five-stage CIC interpolator.
// Low-rate samples arrive through a one-entry valid/ready buffer. Once per
// INTERP cycles a boundary runs the comb section on the buffered sample.
// The comb result is zero-stuffed into five integrators that run every clock.
// Their output is scaled by a gain-controlled arithmetic shift.
module cic_interp #(
    parameter int WIDTH     = 64,
    parameter int INTERP    = 4096,
    parameter int BITS      = 16,
    parameter int GAIN_BITS = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic signed [BITS-1:0] x_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [GAIN_BITS-1:0]   gain,
    output logic signed [BITS-1:0] x_out,
    output logic                   underrun
);

    localparam int          N    = 5;
    localparam logic [15:0] LAST = 16'(INTERP - 1);

    logic [15:0]             count_r;
    logic signed [BITS-1:0]  buf_r;
    logic                    buf_full_r;
    logic signed [WIDTH-1:0] d_r [N];
    logic signed [WIDTH-1:0] comb_out_r;
    logic                    stuff_r;
    logic signed [WIDTH-1:0] integ_r [N];

    logic                    boundary_s;
    logic                    transfer_s;
    logic signed [WIDTH-1:0] c_s [N];
    logic signed [WIDTH-1:0] comb5_s;
    logic signed [WIDTH-1:0] integ_in_s;
    logic signed [WIDTH-1:0] shifted_s;
    int                      shift_s;

    assign in_ready = !buf_full_r;
    // A boundary that finds the buffer empty stuffs a zero and flags it.
    // The flag is held low while RST is asserted.
    assign underrun = !RST && boundary_s && !buf_full_r;

    // Boundary detect, handshake, comb chain, stuffer mux and output shift.
    always_comb begin
        logic signed [WIDTH-1:0] acc;
        boundary_s = (count_r == LAST);
        transfer_s = in_valid && !buf_full_r;
        if (buf_full_r) begin
            acc = {{(WIDTH-BITS){buf_r[BITS-1]}}, buf_r};
        end else begin
            acc = {WIDTH{1'b0}};
        end
        // c_s[k] is the input of comb stage k+1; it is also the next value
        // of that stage's delay register.
        for (int k = 0; k < N; k++) begin
            c_s[k] = acc;
            acc    = acc - d_r[k];
        end
        comb5_s = acc;
        if (stuff_r) begin
            integ_in_s = comb_out_r;
        end else begin
            integ_in_s = {WIDTH{1'b0}};
        end
        shift_s   = WIDTH - BITS - int'(gain);
        shifted_s = integ_r[N-1] >>> shift_s;
    end

    // Rate counter: free-running 0..INTERP-1, never stalls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= 16'd0;
        end else if (boundary_s) begin
            count_r <= 16'd0;
        end else begin
            count_r <= count_r + 16'd1;
        end
    end

    // One-entry input buffer. A boundary consumes the buffered sample, and
    // a transfer accepted in that same cycle refills the buffer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_r      <= {BITS{1'b0}};
            buf_full_r <= 1'b0;
        end else begin
            if (transfer_s) begin
                buf_r <= x_in;
            end
            if (boundary_s) begin
                buf_full_r <= transfer_s;
            end else if (transfer_s) begin
                buf_full_r <= 1'b1;
            end
        end
    end

    // Comb delays and comb output advance only on boundary edges.
    // The stuff flag marks the single cycle in which comb_out feeds the
    // integrators.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N; k++) begin
                d_r[k] <= {WIDTH{1'b0}};
            end
            comb_out_r <= {WIDTH{1'b0}};
            stuff_r    <= 1'b0;
        end else if (boundary_s) begin
            for (int k = 0; k < N; k++) begin
                d_r[k] <= c_s[k];
            end
            comb_out_r <= comb5_s;
            stuff_r    <= 1'b1;
        end else begin
            stuff_r    <= 1'b0;
        end
    end

    // Integrator cascade. Modular wrap-around is relied upon, so there is
    // no saturation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N; k++) begin
                integ_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            integ_r[0] <= integ_r[0] + integ_in_s;
            for (int k = 1; k < N; k++) begin
                integ_r[k] <= integ_r[k] + integ_r[k-1];
            end
        end
    end

    // Registered output: gain-adjusted arithmetic shift, truncated to BITS.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_out <= {BITS{1'b0}};
        end else begin
            x_out <= shifted_s[BITS-1:0];
        end
    end

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp.
// Instance A (INTERP=4, WIDTH=24) runs directed tables and hand sequences.
// Instance B (INTERP=16, WIDTH=32) runs full-scale alternating input against
// a direct-form FIR reference, including underruns and a mid-run reset.
module tb_cic_interp;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic               rst_a, va, ready_a, ur_a;
    logic signed [15:0] xa, xo_a;
    logic [2:0]         ga;
    logic               rst_b, vb, ready_b, ur_b;
    logic signed [15:0] xb, xo_b;
    logic [2:0]         gb;

    cic_interp #(.WIDTH(24), .INTERP(4), .BITS(16), .GAIN_BITS(3)) dut_a (
        .CLK(CLK), .RST(rst_a), .x_in(xa), .in_valid(va), .in_ready(ready_a),
        .gain(ga), .x_out(xo_a), .underrun(ur_a)
    );

    cic_interp #(.WIDTH(32), .INTERP(16), .BITS(16), .GAIN_BITS(3)) dut_b (
        .CLK(CLK), .RST(rst_b), .x_in(xb), .in_valid(vb), .in_ready(ready_b),
        .gain(gb), .x_out(xo_b), .underrun(ur_b)
    );

    typedef struct {
        logic               valid;
        logic signed [15:0] x;
        logic [2:0]         gain;
        logic signed [15:0] exp_out;
        logic               exp_rdy;
        logic               exp_ur;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Impulse response of (1+z^-1+z^-2+z^-3)^5.
    int h4[16] = '{1, 5, 15, 35, 65, 101, 135, 155, 155, 135, 101, 65, 35, 15, 5, 1};
    // Step response before it settles at 256 (input 256, gain 0).
    int dc_part[12] = '{1, 5, 15, 35, 66, 106, 150, 190, 221, 241, 251, 255};

    // Reference taps for INTERP=16: (1+...+z^-15)^5, 76 taps.
    longint h16[76];
    longint hist[82];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            va = tbl[i].valid;
            xa = tbl[i].x;
            ga = tbl[i].gain;
            tick();
            check($sformatf("tbl_out[%0d]", i), xo_a, tbl[i].exp_out);
            check($sformatf("tbl_rdy[%0d]", i), ready_a, tbl[i].exp_rdy);
            check($sformatf("tbl_ur[%0d]", i), ur_a, tbl[i].exp_ur);
        end
        tbl.delete();
    endtask

    initial begin
        vec_t   v;
        longint p[76], q[76];
        int     plen;
        int     m_count;
        bit     m_full, alt, bnd, xfer;
        longint m_buf, vin, y;
        logic signed [63:0] ys;
        logic signed [15:0] exp_x;

        rst_a = 1'b1; va = 1'b1; xa = 16'sd256; ga = 3'd0;
        rst_b = 1'b1; vb = 1'b0; xb = 16'sd0;   gb = 3'd0;

        // Reset held 5 cycles with in_valid asserted.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_xout", xo_a, 0);
            check("rst_ur", ur_a, 0);
            check("rst_rdy", ready_a, 1);
        end

        // Impulse: 256 transferred once, zeros afterwards, source always valid.
        for (int i = 0; i < 30; i++) begin
            v.valid   = 1'b1;
            v.x       = (i == 0) ? 16'sd256 : 16'sd0;
            v.gain    = 3'd0;
            v.exp_out = (i >= 9 && i <= 24) ? 16'(h4[i-9]) : 16'sd0;
            v.exp_rdy = ((i + 1) % 4 == 0);
            v.exp_ur  = 1'b0;
            tbl.push_back(v);
        end
        rst_a = 1'b0;
        run_table();

        // DC: constant 256 every interval, gain stepped to 1 at the end.
        rst_a = 1'b1; va = 1'b1; xa = 16'sd256;
        tick();
        check("rst2_xout", xo_a, 0);
        rst_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v.valid = 1'b1;
            v.x     = 16'sd256;
            v.gain  = (i >= 32) ? 3'd1 : 3'd0;
            if (i < 9)        v.exp_out = 16'sd0;
            else if (i < 21)  v.exp_out = 16'(dc_part[i-9]);
            else if (i >= 32) v.exp_out = 16'sd512;
            else              v.exp_out = 16'sd256;
            v.exp_rdy = ((i + 1) % 4 == 0);
            v.exp_ur  = 1'b0;
            tbl.push_back(v);
        end
        run_table();

        // No drift over 10,000 cycles at gain 1.
        for (int i = 0; i < 10000; i++) begin
            tick();
            check("dc_drift", xo_a, 512);
            check("dc_drift_ur", ur_a, 0);
        end

        // Underrun: withhold in_valid across one boundary; gain back to 0.
        // 10040 edges since reset, so a boundary has just consumed the buffer.
        ga = 3'd0; va = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            check("ur_pre_out", xo_a, 256);
            check("ur_pre_rdy", ready_a, 1);
            check($sformatf("ur_pulse[%0d]", j), ur_a, (j == 3));
        end
        // Transfer during the boundary cycle; consumed at the next boundary.
        va = 1'b1; xa = 16'sd256;
        tick();
        check("ur_after_ur", ur_a, 0);
        check("ur_after_rdy", ready_a, 0);
        for (int j = 1; j <= 24; j++) begin
            tick();
            check($sformatf("ur_out[%0d]", j), xo_a,
                  (j >= 6 && j <= 21) ? 256 - h4[j-6] : 256);
            check($sformatf("ur_rdy[%0d]", j), ready_a, (j % 4 == 0));
            check($sformatf("ur_ur[%0d]", j), ur_a, 0);
        end

        // Reset mid-run clears everything on the next edge.
        rst_a = 1'b1;
        tick();
        check("midrst_a_xout", xo_a, 0);
        check("midrst_a_ur", ur_a, 0);
        check("midrst_a_rdy", ready_a, 1);

        // Reference taps for INTERP=16.
        foreach (p[i]) p[i] = 0;
        p[0] = 1; plen = 1;
        repeat (5) begin
            foreach (q[i]) q[i] = 0;
            for (int a = 0; a < plen; a++)
                for (int b = 0; b < 16; b++)
                    q[a+b] += p[a];
            p = q;
            plen += 15;
        end
        foreach (h16[i]) h16[i] = p[i];

        // Full-scale alternating input against the FIR reference.
        m_count = 0; m_full = 1'b0; m_buf = 0; alt = 1'b0;
        foreach (hist[i]) hist[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_b = (cyc < 3) || (cyc == 1500) || (cyc == 1501);
            vb    = (cyc >= 800 && cyc < 840) ? 1'b0 : ($urandom_range(0, 7) != 0);
            xb    = alt ? -16'sd32767 : 16'sd32767;
            gb    = (cyc >= 2200) ? 3'd2 : 3'd0;
            if (rst_b) begin
                m_count = 0; m_full = 1'b0; m_buf = 0;
                foreach (hist[i]) hist[i] = 0;
                exp_x = 16'sd0;
            end else begin
                bnd  = (m_count == 15);
                xfer = vb && !m_full;
                vin  = (bnd && m_full) ? m_buf : 0;
                if (xfer) begin
                    m_buf = longint'(xb);
                    alt   = ~alt;
                end
                if (bnd) begin
                    m_full  = xfer;
                    m_count = 0;
                end else begin
                    if (xfer) m_full = 1'b1;
                    m_count++;
                end
                for (int j = 81; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = vin;
                y = 0;
                for (int k = 0; k < 76; k++) y += h16[k] * hist[6+k];
                ys    = y >>> (16 - int'(gb));
                exp_x = ys[15:0];
            end
            tick();
            check("model_xout", xo_b, exp_x);
            check("model_ur", ur_b, !rst_b && (m_count == 15) && !m_full);
            check("model_rdy", ready_b, !m_full);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
